// File: rtl/notas_pkg.sv
// Shared definitions for the note-word protocol: symbol codes, word types
// and generator state encodings.
package notas_pkg;

    // Symbols are {tom, nota}; the terminator x is always driven as 0000.
    localparam logic [3:0] X    = 4'b0000;
    localparam logic [3:0] DO   = 4'b0001;
    localparam logic [3:0] RE   = 4'b0010;
    localparam logic [3:0] MI   = 4'b0011;
    localparam logic [3:0] FA   = 4'b0100;
    localparam logic [3:0] SOL  = 4'b0101;
    localparam logic [3:0] LA   = 4'b0110;
    localparam logic [3:0] SI   = 4'b0111;
    localparam logic [3:0] DO_M = 4'b1001;
    localparam logic [3:0] RE_M = 4'b1010;
    localparam logic [3:0] MI_M = 4'b1011;
    localparam logic [3:0] FA_M = 4'b1100;
    localparam logic [3:0] SOL_M = 4'b1101;
    localparam logic [3:0] LA_M = 4'b1110;
    localparam logic [3:0] SI_M = 4'b1111;

    localparam logic [1:0] TIPO_NULO = 2'b00;
    localparam logic [1:0] TIPO_ADJ  = 2'b01;
    localparam logic [1:0] TIPO_COMP = 2'b10;
    localparam logic [1:0] TIPO_ADV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } estado_t;

    // A free note of 000 would read as a terminator; map it to do instead.
    function automatic logic [2:0] nota_valida(input logic [2:0] n);
        return (n == 3'd0) ? 3'd1 : n;
    endfunction

endpackage

// File: rtl/tabela_sequencia.sv
// Combinational symbol table: word type, variant and free notes to the
// symbol at a given index plus the word length.
module tabela_sequencia
    import notas_pkg::*;
(
    input  logic [1:0] tipo,
    input  logic       variante,
    input  logic [2:0] n1,
    input  logic [2:0] n2,
    input  logic [2:0] idx,
    output logic [3:0] simbolo,
    output logic [2:0] comprimento
);

    // Length depends only on the type, kept apart so it never sees idx.
    always_comb begin
        comprimento = 3'd1;
        case (tipo)
            TIPO_ADJ:  comprimento = 3'd4;
            TIPO_COMP: comprimento = 3'd5;
            TIPO_ADV:  comprimento = 3'd5;
            default:   comprimento = 3'd1;
        endcase
    end

    // Symbol selection; any index past the word end yields the terminator.
    always_comb begin
        simbolo = X;
        if (tipo != TIPO_NULO) begin
            case (idx)
                3'd0: simbolo = {1'b0, n1};
                3'd1: simbolo = {1'b0, n2};
                3'd2: begin
                    if (tipo == TIPO_ADV) simbolo = LA;
                    else                  simbolo = variante ? SI_M : LA;
                end
                3'd3: begin
                    case (tipo)
                        TIPO_COMP: simbolo = variante ? RE : DO;
                        TIPO_ADV:  simbolo = SI_M;
                        default:   simbolo = X;
                    endcase
                end
                default: simbolo = X;
            endcase
        end
    end

endmodule

// File: rtl/gerador_sequencia_notas.sv
// Note-word transmitter: emits the symbol sequence of the requested word
// type, one ok-strobed symbol every 2+GAP cycles, then pulses fim.
module gerador_sequencia_notas
    import notas_pkg::*;
#(
    parameter int unsigned GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] tipo,
    input  logic       variante,
    input  logic [2:0] nota1,
    input  logic [2:0] nota2,
    output logic [2:0] nota,
    output logic       tom,
    output logic       ok,
    output logic       ocupado,
    output logic       fim
);

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    estado_t    estado, estado_next;
    logic [2:0] idx, idx_next;
    logic [3:0] gap_cnt, gap_next;

    logic [1:0] tipo_q;
    logic       variante_q;
    logic [2:0] n1_q, n2_q;

    logic       aceita;
    logic [1:0] tab_tipo;
    logic       tab_variante;
    logic [2:0] tab_n1, tab_n2;
    logic [3:0] simbolo;
    logic [2:0] comprimento;

    logic [3:0] simbolo_q, simbolo_next;
    logic       ok_next, ocupado_next, fim_next;

    // On the acceptance cycle the table must see the live inputs, because the
    // first symbol is registered on the same edge that latches them.
    assign aceita       = (estado == ST_IDLE) && start;
    assign tab_tipo     = aceita ? tipo : tipo_q;
    assign tab_variante = aceita ? variante : variante_q;
    assign tab_n1       = aceita ? nota_valida(nota1) : n1_q;
    assign tab_n2       = aceita ? nota_valida(nota2) : n2_q;

    tabela_sequencia u_tabela (
        .tipo        (tab_tipo),
        .variante    (tab_variante),
        .n1          (tab_n1),
        .n2          (tab_n2),
        .idx         (idx_next),
        .simbolo     (simbolo),
        .comprimento (comprimento)
    );

    // Next-state, symbol index and gap counter.
    always_comb begin
        estado_next = estado;
        idx_next    = idx;
        gap_next    = gap_cnt;
        case (estado)
            ST_IDLE: begin
                if (start) begin
                    estado_next = ST_SETUP;
                    idx_next    = 3'd0;
                    gap_next    = '0;
                end
            end
            ST_SETUP: estado_next = ST_PULSE;
            ST_PULSE: begin
                estado_next = ST_GAP;
                gap_next    = '0;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_next = '0;
                    if (idx < comprimento - 3'd1) begin
                        idx_next    = idx + 3'd1;
                        estado_next = ST_SETUP;
                    end else begin
                        estado_next = ST_DONE;
                    end
                end else begin
                    gap_next = gap_cnt + 4'd1;
                end
            end
            ST_DONE: estado_next = ST_IDLE;
            default: estado_next = ST_IDLE;
        endcase
    end

    // Output values for the coming state, so outputs leave flip-flops.
    always_comb begin
        ok_next      = (estado_next == ST_PULSE);
        fim_next     = (estado_next == ST_DONE);
        ocupado_next = (estado_next == ST_SETUP) || (estado_next == ST_PULSE) ||
                       (estado_next == ST_GAP);
        simbolo_next = X;
        if (estado_next == ST_SETUP) simbolo_next = simbolo;
        else if (ocupado_next)       simbolo_next = simbolo_q;
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ST_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            simbolo_q <= X;
            ok        <= 1'b0;
            ocupado   <= 1'b0;
            fim       <= 1'b0;
        end else begin
            estado    <= estado_next;
            idx       <= idx_next;
            gap_cnt   <= gap_next;
            simbolo_q <= simbolo_next;
            ok        <= ok_next;
            ocupado   <= ocupado_next;
            fim       <= fim_next;
        end
    end

    // Request latch, loaded only when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            tipo_q     <= TIPO_NULO;
            variante_q <= 1'b0;
            n1_q       <= 3'd1;
            n2_q       <= 3'd1;
        end else if (aceita) begin
            tipo_q     <= tipo;
            variante_q <= variante;
            n1_q       <= nota_valida(nota1);
            n2_q       <= nota_valida(nota2);
        end
    end

    assign tom  = simbolo_q[3];
    assign nota = simbolo_q[2:0];

endmodule

// File: tb/tb_gerador_sequencia_notas.sv
// Self-checking bench for gerador_sequencia_notas (GAP=2 and GAP=1 instances).
module tb_gerador_sequencia_notas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, variante;
    logic [1:0] tipo;
    logic [2:0] nota1, nota2, nota;
    logic       tom, ok, ocupado, fim;

    logic       start_b, variante_b;
    logic [1:0] tipo_b;
    logic [2:0] nota1_b, nota2_b, nota_b;
    logic       tom_b, ok_b, ocupado_b, fim_b;

    int n_cmp = 0;
    int n_bad = 0;

    gerador_sequencia_notas #(.GAP(2)) dut (
        .clk(clk), .reset(reset), .start(start), .tipo(tipo), .variante(variante),
        .nota1(nota1), .nota2(nota2), .nota(nota), .tom(tom), .ok(ok),
        .ocupado(ocupado), .fim(fim)
    );

    gerador_sequencia_notas #(.GAP(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tipo(tipo_b), .variante(variante_b),
        .nota1(nota1_b), .nota2(nota2_b), .nota(nota_b), .tom(tom_b), .ok(ok_b),
        .ocupado(ocupado_b), .fim(fim_b)
    );

    // Reference word: symbol list and length straight from the protocol rules.
    function automatic void modelo(input logic [1:0] t, input logic v,
                                   input logic [2:0] a, input logic [2:0] b,
                                   output logic [3:0] seq [5], output int len);
        logic [3:0] s1, s2;
        s1 = {1'b0, (a == 3'd0) ? 3'd1 : a};
        s2 = {1'b0, (b == 3'd0) ? 3'd1 : b};
        for (int i = 0; i < 5; i++) seq[i] = 4'b0000;
        case (t)
            2'b01: begin seq[0] = s1; seq[1] = s2; seq[2] = v ? 4'b1111 : 4'b0110; len = 4; end
            2'b10: begin
                seq[0] = s1; seq[1] = s2; seq[2] = v ? 4'b1111 : 4'b0110;
                seq[3] = v ? 4'b0010 : 4'b0001; len = 5;
            end
            2'b11: begin seq[0] = s1; seq[1] = s2; seq[2] = 4'b0110; seq[3] = 4'b1111; len = 5; end
            default: len = 1;
        endcase
    endfunction

    // Expected {ocupado,fim,ok,tom,nota} in cycle k after the accepting edge.
    function automatic logic [6:0] esperado(input int k, input int len, input int g,
                                            input logic [3:0] seq [5]);
        int per, total;
        per   = 2 + g;
        total = len * per;
        if (k <= total)
            return {1'b1, 1'b0, ((k - 1) % per) == 1, seq[(k - 1) / per]};
        else if (k == total + 1)
            return 7'b0100000;
        return 7'b0000000;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_b = 1'b0;
        tipo = 2'b00; variante = 1'b0; nota1 = 3'd0; nota2 = 3'd0;
        tipo_b = 2'b01; variante_b = 1'b0; nota1_b = 3'd1; nota2_b = 3'd1;
        repeat (3) @(negedge clk);
        if ({ocupado, fim, ok, tom, nota} !== 7'b0) begin
            $display("FAIL reset_a: got %b want 0000000", {ocupado, fim, ok, tom, nota});
            n_bad++;
        end
        n_cmp++;
        if ({ocupado_b, fim_b, ok_b, tom_b, nota_b} !== 7'b0) begin
            $display("FAIL reset_b: got %b want 0000000", {ocupado_b, fim_b, ok_b, tom_b, nota_b});
            n_bad++;
        end
        n_cmp++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One word on the GAP=2 instance; perturb scrambles start and inputs while busy.
    task automatic test_word(input logic [1:0] t, input logic v, input logic [2:0] a,
                             input logic [2:0] b, input bit perturb);
        logic [3:0] seq [5];
        int len, total;
        logic [6:0] exp_v, got;
        modelo(t, v, a, b, seq, len);
        total = len * 4;
        @(negedge clk);
        tipo = t; variante = v; nota1 = a; nota2 = b; start = 1'b1;
        for (int k = 1; k <= total + 2; k++) begin
            @(negedge clk);
            if (perturb && k <= total) begin
                start = 1'($urandom); tipo = 2'($urandom); variante = 1'($urandom);
                nota1 = 3'($urandom); nota2 = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            exp_v = esperado(k, len, 2, seq);
            got   = {ocupado, fim, ok, tom, nota};
            if (got !== exp_v) begin
                $display("FAIL word t=%b v=%b n=%0d,%0d cyc %0d: got %b want %b (ocup,fim,ok,tom,nota)",
                         t, v, a, b, k, got, exp_v);
                n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] seq [5];
        int len;
        logic [6:0] exp_v, got;
        modelo(2'b01, 1'b0, 3'd3, 3'd5, seq, len);
        @(negedge clk);
        tipo = 2'b01; variante = 1'b0; nota1 = 3'd3; nota2 = 3'd5; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_v = (k <= 7) ? esperado(k, len, 2, seq) : 7'b0;
            got   = {ocupado, fim, ok, tom, nota};
            if (got !== exp_v) begin
                $display("FAIL abort cyc %0d: got %b want %b", k, got, exp_v);
                n_bad++;
            end
            n_cmp++;
            if (k == 7)  reset = 1'b1;
            if (k == 10) reset = 1'b0;
        end
        test_word(2'b01, 1'b0, 3'd3, 3'd5, 1'b0);
    endtask

    // GAP=1, start held high: adjective words back to back, one IDLE cycle apart.
    task automatic test_back_to_back();
        logic [3:0] seq [5];
        int len;
        logic [6:0] exp_v, got;
        @(negedge clk);
        tipo_b = 2'b01; variante_b = 1'($urandom); nota1_b = 3'($urandom); nota2_b = 3'($urandom);
        start_b = 1'b1;
        for (int w = 0; w < 3; w++) begin
            modelo(2'b01, variante_b, nota1_b, nota2_b, seq, len);
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                exp_v = esperado(k, len, 1, seq);
                got   = {ocupado_b, fim_b, ok_b, tom_b, nota_b};
                if (got !== exp_v) begin
                    $display("FAIL b2b word %0d cyc %0d: got %b want %b", w, k, got, exp_v);
                    n_bad++;
                end
                n_cmp++;
                if (k == 14) begin
                    if (w < 2) begin
                        variante_b = 1'($urandom); nota1_b = 3'($urandom); nota2_b = 3'($urandom);
                    end else begin
                        start_b = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word(2'b01, 1'b0, 3'd3, 3'd5, 1'b0);
        test_word(2'b10, 1'b1, 3'd1, 3'd7, 1'b0);
        test_word(2'b11, 1'b0, 3'd0, 3'd2, 1'b0);
        test_word(2'b00, 1'b0, 3'd4, 3'd4, 1'b0);
        test_word(2'b01, 1'b0, 3'd3, 3'd5, 1'b1);
        for (int r = 0; r < 10; r++)
            test_word(2'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 1'(r % 2));
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gerador_sequencia_notas.md
Name: gerador_sequencia_notas

Overview:
Transmit side of the note-word protocol. From a requested word type (adjective, comparative or adverb), it generates the matching note-symbol sequence and terminator. Each symbol is presented on nota/tom and strobed with ok, so the word-classifier FSM can consume it directly. The block sits between the test/keyboard front end and the classifier, and serves as the stimulus source for board demos and the regression bench.

Parameters:
GAP, 2, number of idle cycles with ok low after each ok pulse; legal range 1..15.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request a word; sampled only in IDLE
tipo  input  2  requested type: 00 null/error, 01 adjective, 10 comparative, 11 adverb
variante  input  1  selects the third-note branch: 0 = la, 1 = si menor; ignored for adverb
nota1  input  3  first free note (1..7)
nota2  input  3  second free note (1..7)
nota  output  3  current symbol's note field
tom  output  1  current symbol's minor flag
ok  output  1  one-cycle strobe; symbol is valid while ok is high
ocupado  output  1  high from the cycle after start is accepted through the last GAP cycle
fim  output  1  one-cycle pulse when the sequence is complete

Behaviour:
- Symbol encoding is {tom, nota}.
  - 0000 and 1000 are the terminator "x".
  - 0001..0111 are do..si.
  - 1001..1111 are do_m..si_m.
- Reset values: nota=000, tom=0, ok=0, ocupado=0, fim=0, state IDLE, indices cleared. Reset mid-sequence aborts on the next edge; no further ok pulse is issued.
- Inputs are latched in the start-acceptance cycle. Later input changes have no effect until the next start.
- If nota1 or nota2 is 000 when latched, it is replaced by 001 (do), so a valid word is never corrupted.
- Sequences (index 0 first):
  - adjective, variante 0: n1, n2, la(0110), x → length 4
  - adjective, variante 1: n1, n2, si_m(1111), x → length 4
  - comparative, variante 0: n1, n2, la, do(0001), x → length 5
  - comparative, variante 1: n1, n2, si_m, re(0010), x → length 5
  - adverb: n1, n2, la, si_m, x → length 5
  - null: x → length 1 (drives the classifier to its error state)
- Terminator is always driven as 0000.
- State machine:
  - IDLE: if start=1, go to SETUP with idx=0; otherwise stay. start in any other state is ignored.
  - SETUP (1 cycle): nota/tom drive symbol[idx]; ok=0.
  - PULSE (1 cycle): ok=1; nota/tom held.
  - GAP (GAP cycles): ok=0; nota/tom held. On the last gap cycle:
    - if idx < len-1: idx++, go to SETUP;
    - else go to DONE.
  - DONE (1 cycle): fim=1, ocupado=0, nota/tom return to 0000; next state IDLE.
- Timing:
  - ocupado is high in SETUP, PULSE and GAP.
  - Cycles per symbol = 2 + GAP.
  - With start sampled at edge 0, fim is high in cycle len*(2+GAP)+1.
- Symbol data is stable for one cycle before ok rises and GAP cycles after it falls. This satisfies a receiver that samples on ok and advances on clk.
- start held high continuously: a new word begins in the IDLE cycle after DONE, so there is exactly one IDLE cycle between words.
- Gap counter is 4 bits; symbol index is 3 bits; length is 3 bits.

Decomposition:
- Shared package notas_pkg holds:
  - symbol constants (X, DO..SI, DO_M..SI_M, 4-bit);
  - tipo codes (TIPO_NULO, TIPO_ADJ, TIPO_COMP, TIPO_ADV);
  - FSM state encodings.
  The classifier uses the same package.
- One combinational sub-module, tabela_sequencia:
  - inputs: tipo, variante, n1, n2, idx;
  - outputs: simbolo[3:0] and comprimento[2:0].
  The top level keeps the FSM, counters and output registers.

Test Plan:
1. reset, then start with tipo=01, variante=0, nota1=3, nota2=5 → ok pulses in cycles 2, 6, 10, 14 with {tom,nota}=0011, 0101, 0110, 0000; fim=1 in cycle 17; ocupado=0 afterwards.
2. tipo=10, variante=1, nota1=1, nota2=7 → symbols 0001, 0111, 1111, 0010, 0000; fim in cycle 21.
3. tipo=11, nota1=0, nota2=2 → symbols 0001 (substituted), 0010, 0110, 1111, 0000; fim in cycle 21.
4. tipo=00 → a single ok pulse with 0000 in cycle 2; fim in cycle 5.
5. start re-pulsed during a sequence, and inputs changed mid-sequence → output unchanged from case 1. Then reset asserted in cycle 7 → from the next cycle ok=0, nota=000, ocupado=0 and no fim; a new start afterwards produces a full correct sequence.
6. GAP=1 with start held high → back-to-back adjective words with a 3-cycle ok spacing and exactly one IDLE cycle between the fim pulse and the next SETUP. Connected to the classifier, each run ends with the classifier showing fim=1 and tipo equal to the requested type.
